// File: rtl/addersub_result_stage.sv
// Result stage after the add/sub/SLT unit: forms the writeback word and holds it in a
// 2-entry skid buffer (head + skid). Optional overflow trap enabled by ADDERSUB_OVF_TRAP_EN.
module addersub_result_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_result_slt,
    input  logic [REG_BITS-1:0]   in_dst,
    input  logic                  in_opA_msb,
    input  logic                  in_opB_msb,
    input  logic                  squash,
    input  logic                  out_stall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [REG_BITS-1:0]   out_dst,
    output logic                  out_we,
    output logic                  out_ovf,
    output logic                  fwd_valid,
    output logic [REG_BITS-1:0]   fwd_dst,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_reg, state_next;

    logic [DATA_WIDTH-1:0] head_data_reg, head_data_next;
    logic [REG_BITS-1:0]   head_dst_reg,  head_dst_next;
    logic                  head_we_reg,   head_we_next;
    logic                  head_ovf_reg,  head_ovf_next;

    logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic [REG_BITS-1:0]   skid_dst_reg,  skid_dst_next;
    logic                  skid_we_reg,   skid_we_next;
    logic                  skid_ovf_reg,  skid_ovf_next;

    logic [DATA_WIDTH-1:0] cap_data;
    logic                  cap_we;
    logic                  cap_ovf;
    logic                  accept;
    logic                  pop;

    // SLT-class ops write the compare bit zero-extended; everything else writes the sum.
    assign cap_data = in_op[2] ? {{(DATA_WIDTH-1){1'b0}}, in_result_slt} : in_result;

`ifdef ADDERSUB_OVF_TRAP_EN
    logic is_add;
    logic is_sub;
    logic res_msb;

    assign is_add  = (in_op == 3'd3);
    assign is_sub  = (in_op == 3'd2);
    assign res_msb = in_result[DATA_WIDTH-1];
    assign cap_ovf = (is_add && (in_opA_msb == in_opB_msb) && (res_msb != in_opA_msb)) ||
                     (is_sub && (in_opA_msb != in_opB_msb) && (res_msb != in_opA_msb));
`else
    logic unused_inputs;

    assign unused_inputs = ^{in_opA_msb, in_opB_msb, in_op[1:0]};
    assign cap_ovf       = 1'b0;
`endif

    // A trapping result must not reach the register file.
    assign cap_we = (in_dst != '0) && !cap_ovf;

    // Ready depends only on registered occupancy so no combinational path from out_stall.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && !out_stall;

    always_comb begin
        state_next     = state_reg;
        head_data_next = head_data_reg;
        head_dst_next  = head_dst_reg;
        head_we_next   = head_we_reg;
        head_ovf_next  = head_ovf_reg;
        skid_data_next = skid_data_reg;
        skid_dst_next  = skid_dst_reg;
        skid_we_next   = skid_we_reg;
        skid_ovf_next  = skid_ovf_reg;

        if (squash) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        head_data_next = cap_data;
                        head_dst_next  = in_dst;
                        head_we_next   = cap_we;
                        head_ovf_next  = cap_ovf;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_data_next = cap_data;
                        head_dst_next  = in_dst;
                        head_we_next   = cap_we;
                        head_ovf_next  = cap_ovf;
                    end else if (accept) begin
                        skid_data_next = cap_data;
                        skid_dst_next  = in_dst;
                        skid_we_next   = cap_we;
                        skid_ovf_next  = cap_ovf;
                        state_next     = FULL;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // Upstream is blocked here, so only a pop can change anything.
                    if (pop) begin
                        head_data_next = skid_data_reg;
                        head_dst_next  = skid_dst_reg;
                        head_we_next   = skid_we_reg;
                        head_ovf_next  = skid_ovf_reg;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            head_data_reg <= '0;
            head_dst_reg  <= '0;
            head_we_reg   <= 1'b0;
            head_ovf_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_dst_reg  <= '0;
            skid_we_reg   <= 1'b0;
            skid_ovf_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            head_data_reg <= head_data_next;
            head_dst_reg  <= head_dst_next;
            head_we_reg   <= head_we_next;
            head_ovf_reg  <= head_ovf_next;
            skid_data_reg <= skid_data_next;
            skid_dst_reg  <= skid_dst_next;
            skid_we_reg   <= skid_we_next;
            skid_ovf_reg  <= skid_ovf_next;
        end
    end

    assign out_data  = head_data_reg;
    assign out_dst   = head_dst_reg;
    assign out_we    = head_we_reg;
    assign out_ovf   = head_ovf_reg;
    assign fwd_valid = out_valid && head_we_reg;
    assign fwd_dst   = head_dst_reg;
    assign fwd_data  = head_data_reg;

endmodule

// File: doc/addersub_result_stage.md
Name: addersub_result_stage

Overview:
- Pipeline stage directly downstream of the 32-bit add/sub/SLT unit.
- Registers the adder's 32-bit sum and its SLT bit, and forms the final writeback word.
  - SLT/SLTU ops produce a zero-extended compare bit.
  - All other ops pass the sum through.
- Decouples the ALU from writeback with a 2-entry skid buffer, a valid/stall handshake and a squash input.
- Exposes the head entry as a forwarding source for operand bypass.

Parameters:
- DATA_WIDTH, 32, width of the result word.
- REG_BITS, 5, width of the destination-register index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid ALU result.
- in_ready  output  1  stage can accept this cycle.
- in_op  input  3  ALU op code {is_slt, signext, addsub}.
- in_result  input  DATA_WIDTH  adder sum[31:0].
- in_result_slt  input  1  adder sum[32] (compare/borrow bit).
- in_dst  input  REG_BITS  destination register index.
- in_opA_msb  input  1  opA[31]; used only with the optional feature.
- in_opB_msb  input  1  opB[31]; used only with the optional feature.
- squash  input  1  synchronous flush of all held entries.
- out_stall  input  1  writeback cannot accept this cycle.
- out_valid  output  1  head entry valid.
- out_data  output  DATA_WIDTH  writeback word.
- out_dst  output  REG_BITS  destination index.
- out_we  output  1  register write enable.
- out_ovf  output  1  overflow trap flag for the head entry.
- fwd_valid  output  1  head entry valid and writes a register.
- fwd_dst  output  REG_BITS  forwarding destination (= out_dst).
- fwd_data  output  DATA_WIDTH  forwarding data (= out_data).

Behaviour:
- Reset (async, active-high): count=0; out_valid=0, out_data=0, out_dst=0, out_we=0, out_ovf=0, fwd_valid=0; in_ready=1 once reset is released. Reset during any state discards all entries.
- Word formation at capture:
  - in_op[2]=1: data = {31'b0, in_result_slt}.
  - in_op[2]=0: data = in_result.
  - we = (in_dst != 0) and not overflow-suppressed.
- Storage: head register plus skid register. count in {0,1,2}; states EMPTY, ONE, FULL.
- in_ready = (count != 2). It is derived from registered state only, never combinationally from out_stall.
- Accept = in_valid & in_ready. Pop = out_valid & !out_stall.
- EMPTY:
  - accept -> ONE; entry appears at the head the next cycle (latency 1).
- ONE:
  - accept & pop -> ONE; head replaced by the new entry.
  - accept & !pop -> FULL; new entry goes to skid.
  - pop & !accept -> EMPTY.
  - otherwise hold.
- FULL (in_ready=0):
  - pop -> ONE; skid moves to head.
  - otherwise hold.
- Ordering strictly FIFO; no entry is dropped or duplicated.
- squash: next state EMPTY, overriding any accept or pop that cycle; out_valid=0 next cycle. Reset has priority over squash.
- While out_stall=1, head outputs are held stable.
- out_data, out_dst and out_we are don't-care when out_valid=0 but must not be X after reset.
- fwd_valid = out_valid & out_we.

Optional Feature:
- Macro ADDERSUB_OVF_TRAP_EN.
- Defined:
  - ADD (op=3): ovf = (A==B) & (result[31]!=A).
  - SUB (op=2): ovf = (A!=B) & (result[31]!=A).
  - A and B are in_opA_msb and in_opB_msb. Ops 0, 1, 4, 6 never overflow.
  - ovf is stored with the entry; out_ovf=ovf; an overflowing entry has out_we=0.
- Not defined:
  - out_ovf tied 0.
  - in_opA_msb and in_opB_msb unused.
  - out_we = (dst != 0).

Test Plan:
- Single ADDU, op=1, result=0x0000_0007, dst=3, no stall -> one cycle later out_valid=1, out_data=0x7, out_dst=3, out_we=1.
- SLT, op=6, in_result=0xFFFF_FFFF, in_result_slt=1, dst=8 -> out_data=0x0000_0001; same with slt=0 -> 0x0.
- Hold out_stall=1 and present 3 back-to-back entries (values 0xA, 0xB, 0xC):
  - in_ready drops after 2 are accepted; the third is held upstream.
  - Release the stall -> outputs 0xA, 0xB, 0xC in order, one per cycle.
- FULL state, assert squash alongside in_valid -> next cycle out_valid=0, count=0, in_ready=1; the squashed input is not captured.
- dst=0 with op=3 -> out_valid=1, out_we=0, fwd_valid=0.
- With ADDERSUB_OVF_TRAP_EN, ADD of opA=0x7FFF_FFFF and opB=0x1 (result 0x8000_0000, msbs 0,0) -> out_ovf=1, out_we=0. Same stimulus with the macro undefined -> out_ovf=0, out_we=1.
